// File: rtl/uart_tx_queue_pkg.sv
// Shared peripheral definitions for the buffered UART transmitter:
// bus addresses, CON register bit positions and TX state encoding.
package uart_tx_queue_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_FULL   = 0;
  localparam int CON_EMPTY  = 1;
  localparam int CON_BUSY   = 2;
  localparam int CON_IRQ_EN = 3;
  localparam int CON_DONE   = 4;
  localparam int CON_OVF    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two; head is shown on dout.
// Ports: clk, reset, push/din, pop/dout, full, empty, count.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // a pop frees the slot this cycle, so a push to a full FIFO
  // is still taken when it coincides with a pop
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is never cleared; only the pointers matter
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Memory-mapped buffered 8N1 UART transmitter with done interrupt.
// Ports: clk, reset, wr/rd/addr/wdata/rdata bus, UART_TX, irqout.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int CLK_DIV = 217,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  tx_state_e state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          baud_end;

  logic irq_en, done, ovf;
  logic done_set;

  logic txd_sel, con_sel;
  logic push, pop, con_wr;
  logic full, empty, busy;
  logic [7:0] fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic unused_bits;

  assign txd_sel = (addr == UART_TXD_ADDR);
  assign con_sel = (addr == UART_CON_ADDR);
  assign push    = wr & txd_sel;
  assign con_wr  = wr & con_sel;
  assign busy    = (state != IDLE) | ~empty;

  assign unused_bits = ^{wdata[31:8], fifo_count};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign baud_end = (baud == BAUD_LAST);

  always_comb begin
    state_n  = state;
    baud_n   = baud + BW'(1);
    bit_n    = bit_idx;
    shift_n  = shift;
    pop      = 1'b0;
    done_set = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n   = '0;
          done_set = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // line level is registered from the next state so it is glitch-free
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      UART_TX <= tx_n;
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      irqout <= 1'b0;
    end else begin
      if (con_wr)
        irq_en <= wdata[CON_IRQ_EN];
      if (done_set)
        done <= 1'b1;
      else if (con_wr && wdata[CON_DONE])
        done <= 1'b0;
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (con_wr && wdata[CON_OVF])
        ovf <= 1'b0;
      irqout <= done & irq_en;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && con_sel) begin
      rdata[CON_FULL]   = full;
      rdata[CON_EMPTY]  = empty;
      rdata[CON_BUSY]   = busy;
      rdata[CON_IRQ_EN] = irq_en;
      rdata[CON_DONE]   = done;
      rdata[CON_OVF]    = ovf;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with CLK_DIV=4, DEPTH=4.
// A line monitor decodes frames; scenario tasks check results.
module tb_uart_tx_queue;
  import uart_tx_queue_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int PERIOD  = 10 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        UART_TX;
  logic        irqout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } frame_t;

  frame_t frames[$];

  uart_tx_queue #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .UART_TX (UART_TX),
    .irqout  (irqout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset)
      rst_cnt <= rst_cnt + 1;
  end

  // frame decoder: start edge, mid-bit samples, discarded on reset
  initial begin : line_mon
    frame_t f;
    int r0;
    forever begin
      @(negedge UART_TX);
      #1;
      f.start = cyc;
      f.ok = 1'b1;
      f.data = '0;
      r0 = rst_cnt;
      repeat (2) @(posedge clk);
      #1;
      if (UART_TX !== 1'b0) f.ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (CLK_DIV) @(posedge clk);
        #1;
        f.data[k] = UART_TX;
      end
      repeat (CLK_DIV) @(posedge clk);
      #1;
      if (UART_TX !== 1'b1) f.ok = 1'b0;
      if (rst_cnt == r0)
        frames.push_back(f);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a,
                           input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic bus_read(input  logic [31:0] a,
                          output logic [31:0] v);
    addr = a;
    rd   = 1'b1;
    #1;
    v    = rdata;
    rd   = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    checks++;
    if (UART_TX !== 1'b1) begin
      failures++;
      $display("FAIL rst_tx: got %b want 1", UART_TX);
    end
    checks++;
    if (irqout !== 1'b0) begin
      failures++;
      $display("FAIL rst_irq: got %b want 0", irqout);
    end
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h02) begin
      failures++;
      $display("FAIL rst_con: got %h want 02", v);
    end
    bus_read(UART_TXD_ADDR, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL txd_read: got %h want 0", v);
    end
    addr = UART_CON_ADDR;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL no_rd: got %h want 0", rdata);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    int e;
    frames.delete();
    bus_write(UART_TXD_ADDR, 32'hA5);
    e = cyc;
    repeat (40) tick();
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h06) begin
      failures++;
      $display("FAIL con_stop: got %h want 06", v);
    end
    tick();
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h12) begin
      failures++;
      $display("FAIL con_done: got %h want 12", v);
    end
    checks++;
    if (frames.size() !== 1) begin
      failures++;
      $display("FAIL a5_count: got %0d want 1", frames.size());
    end else begin
      checks++;
      if (frames[0].data !== 8'hA5 || !frames[0].ok) begin
        failures++;
        $display("FAIL a5_data: got %h ok=%0d want a5 ok=1",
                 frames[0].data, frames[0].ok);
      end
      checks++;
      if (frames[0].start !== e + 1) begin
        failures++;
        $display("FAIL a5_start: got %0d want %0d",
                 frames[0].start, e + 1);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    do_reset();
    bus_write(UART_CON_ADDR, 32'h08);
    frames.delete();
    bus_write(UART_TXD_ADDR, 32'h3C);
    repeat (41) tick();
    checks++;
    if (irqout !== 1'b0) begin
      failures++;
      $display("FAIL irq_early: got %b want 0", irqout);
    end
    tick();
    checks++;
    if (irqout !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: got %b want 1", irqout);
    end
    checks++;
    if (frames.size() !== 1 || frames[0].data !== 8'h3C) begin
      failures++;
      $display("FAIL irq_frame: got n=%0d want one 3c",
               frames.size());
    end
    bus_write(UART_CON_ADDR, 32'h18);
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h0A) begin
      failures++;
      $display("FAIL irq_con: got %h want 0a", v);
    end
    tick();
    checks++;
    if (irqout !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear: got %b want 0", irqout);
    end
  endtask

  task automatic test_overflow_full_pop();
    logic [31:0] v;
    logic [7:0] exp_d [6];
    int e1;
    int n;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
    do_reset();
    frames.delete();
    addr = UART_TXD_ADDR;
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 32'(8'h11 * (i + 1));
      tick();
      if (i == 0) e1 = cyc;
    end
    wr = 1'b0;
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h25) begin
      failures++;
      $display("FAIL ovf_con: got %h want 25", v);
    end
    bus_write(UART_CON_ADDR, 32'h20);
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h05) begin
      failures++;
      $display("FAIL ovf_clr: got %h want 05", v);
    end
    repeat (e1 + 41 - cyc) tick();
    bus_write(UART_TXD_ADDR, 32'h77);
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h15) begin
      failures++;
      $display("FAIL push_pop: got %h want 15", v);
    end
    n = 0;
    while (frames.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (frames.size() !== 6) begin
      failures++;
      $display("FAIL burst_count: got %0d want 6",
               frames.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (frames[i].data !== exp_d[i] || !frames[i].ok ||
            frames[i].start !== e1 + 1 + PERIOD * i) begin
          failures++;
          $display("FAIL burst_%0d: got %h@%0d want %h@%0d",
                   i, frames[i].data, frames[i].start,
                   exp_d[i], e1 + 1 + PERIOD * i);
        end
      end
    end
    repeat (60) tick();
    checks++;
    if (frames.size() !== 6) begin
      failures++;
      $display("FAIL burst_extra: got %0d want 6",
               frames.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int lows;
    do_reset();
    frames.delete();
    addr = UART_TXD_ADDR;
    wr = 1'b1;
    wdata = 32'h81;
    tick();
    wdata = 32'h42;
    tick();
    wdata = 32'hC3;
    tick();
    wr = 1'b0;
    repeat (16) tick();
    checks++;
    if (UART_TX !== 1'b0) begin
      failures++;
      $display("FAIL bit3_level: got %b want 0", UART_TX);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (UART_TX !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_tx: got %b want 1", UART_TX);
    end
    bus_read(UART_CON_ADDR, v);
    checks++;
    if (v !== 32'h02) begin
      failures++;
      $display("FAIL mid_rst_con: got %h want 02", v);
    end
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (UART_TX !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0 || frames.size() !== 0) begin
      failures++;
      $display("FAIL post_rst: got lows=%0d frames=%0d want 0 0",
               lows, frames.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_irq();
    test_overflow_full_pop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Memory-mapped, buffered UART transmitter in the peripheral address space, downstream of the CPU store path. The CPU writes bytes faster than the serial line drains them. This block accepts them into a FIFO and serialises them as 8N1 frames on UART_TX. It also raises a completion interrupt that is merged into the CPU's IRQ. Selection is `wr/rd` qualified by ALU_out[30], as for every other peripheral.

## Interface
- CLK_DIV, 217: clk cycles per bit (25 MHz / 115200).
- DEPTH, 8: FIFO entries; power of two, ≥2.
- clk  in  1  25 MHz system clock (sysclk_25M domain).
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- wr  in  1  bus write strobe (already peripheral-qualified).
- rd  in  1  bus read strobe.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational; 0 when not rd or address unmapped.
- UART_TX  out  1  serial line, idle high.
- irqout  out  1  level interrupt = done & irq_en.

## Operation
- 0x40000018 TXD: a write pushes wdata[7:0]. A read returns 0.
- 0x40000020 CON read: {26'b0, ovf, done, irq_en, busy, empty, full}.
  - Bits [5:0] = ovf, done, irq_en, busy, empty, full.
- 0x40000020 CON write:
  - wdata[3] loads irq_en.
  - wdata[4]=1 clears done.
  - wdata[5]=1 clears ovf.
- FIFO: DEPTH entries; wr_ptr/rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - full = count==DEPTH; empty = count==0.
- Push to full FIFO without a same-cycle pop: data dropped, ovf set (sticky).
- Push to full FIFO with a same-cycle pop: push accepted; count unchanged.
- Simultaneous push and pop on an empty FIFO cannot occur: pop requires !empty at the cycle start.
- TX FSM states: IDLE, START, DATA, STOP.
  - A single baud counter 0..CLK_DIV-1 advances each state; it resets on every state entry.
  - IDLE: UART_TX=1. If !empty: pop the head into an 8-bit shift register, go to START.
  - START: UART_TX=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: UART_TX=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right and increment bit index. After bit 7, go to STOP.
  - STOP: UART_TX=1 for CLK_DIV cycles. On exit, set done and return to IDLE.
- busy = (state != IDLE) | !empty.
- Simultaneous CON write clearing done and a STOP exit setting done: set wins.
- Writes to CON never disturb the FIFO or an in-flight frame.
- Reset mid-frame:
  - FSM returns to IDLE and UART_TX goes high on the next edge; the partial frame is abandoned.
  - FIFO is emptied (pointers and count zeroed); stored data is not cleared.

## Timing
- Reset values:
  - UART_TX=1, irqout=0, rdata=0.
  - State IDLE; count 0; irq_en, done and ovf all 0.
- Idle line, empty FIFO: a TXD write at edge E makes the FIFO non-empty after E.
  - At E+1 the FSM pops and enters START.
  - UART_TX is low from E+1 through E+1+CLK_DIV.
  - The frame occupies exactly 10·CLK_DIV cycles. done rises at E+1+10·CLK_DIV.
- Back-to-back frames: IDLE lasts exactly one cycle between STOP exit and the next START, so the frame period is 10·CLK_DIV+1.
- irqout follows done/irq_en one cycle after the register update. There is no combinational path from bus to irqout.
- Reads have zero latency. A read of CON in the push cycle shows the pre-push flags.

## Structure
- Shared peripheral package holds:
  - address constants UART_TXD_ADDR and UART_CON_ADDR;
  - CON bit-index constants;
  - the TX state encoding (2-bit enum).
- One sub-module, `sync_fifo` (parameters DEPTH, WIDTH=8), with push/pop/full/empty/count.
  - Owns the pointers and the simultaneous push/pop rule.
- FSM, baud counter, registers and bus decode live in uart_tx_queue.

## Test plan
All scenarios use CLK_DIV=4 and DEPTH=4.
- Reset high for 2 cycles, then release.
  - UART_TX=1, irqout=0.
  - CON read = 0x02 (empty only).
- Write 0xA5 to TXD at edge E.
  - UART_TX samples at mid-bit: 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
  - Low edge at E+1; done=1 at E+41.
- Write CON=0x08, then send 0x3C.
  - irqout=1 one cycle after done sets.
  - Write CON=0x18: irqout=0 next cycle; irq_en stays 1.
- Six TXD writes in consecutive cycles while line idle.
  - The first is popped at E+1, so 5 are accepted and the 6th is dropped: ovf=1, full=1.
  - Exactly 5 frames appear, each 41 cycles apart, in write order.
- With FIFO full, write TXD in the same cycle as the FSM pop.
  - Byte accepted; count stays 4; ovf stays 0.
- Assert reset during DATA bit 3 with 2 bytes queued.
  - UART_TX=1 next cycle; CON=0x02.
  - No further frames are sent.
